// File: rtl/key_cmd_gen.sv
// Debounced two-key command generator: one registered wr/rd pulse per confirmed press.
// Press-to-flag latency is CNT_MAX+4 edges; write wins a same-cycle collision and the read pulse is dropped.
module key_cmd_gen #(
   parameter logic [19:0] CNT_MAX = 20'd999_999
) (
   input  logic sys_clk,
   input  logic sys_rst,
   input  logic key_wr,
   input  logic key_rd,
   output logic wr_flag,
   output logic rd_flag
);

   typedef enum logic [1:0] {IDLE, DOWN_FILT, HELD, UP_FILT} state_t;

   // Index 0 is the write key, index 1 is the read key.
   logic [1:0]  sync1_q;
   logic [1:0]  key_s_q;
   state_t      state_q [2];
   logic [19:0] cnt_q   [2];
   logic [1:0]  press_d;

   always_comb begin
      press_d = 2'b00;
      for (int i = 0; i < 2; i++) begin
         press_d[i] = (state_q[i] == DOWN_FILT) && !key_s_q[i] && (cnt_q[i] == CNT_MAX);
      end
   end

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         sync1_q <= 2'b11;
         key_s_q <= 2'b11;
         for (int i = 0; i < 2; i++) begin
            state_q[i] <= IDLE;
            cnt_q[i]   <= 20'd0;
         end
         wr_flag <= 1'b0;
         rd_flag <= 1'b0;
      end else begin
         sync1_q <= {key_rd, key_wr};
         key_s_q <= sync1_q;
         for (int i = 0; i < 2; i++) begin
            case (state_q[i])
               IDLE: begin
                  if (!key_s_q[i]) begin
                     state_q[i] <= DOWN_FILT;
                     cnt_q[i]   <= 20'd0;
                  end
               end
               DOWN_FILT: begin
                  if (key_s_q[i]) begin
                     state_q[i] <= IDLE;
                     cnt_q[i]   <= 20'd0;
                  end else if (cnt_q[i] == CNT_MAX) begin
                     state_q[i] <= HELD;
                     cnt_q[i]   <= 20'd0;
                  end else begin
                     cnt_q[i] <= cnt_q[i] + 20'd1;
                  end
               end
               HELD: begin
                  if (key_s_q[i]) begin
                     state_q[i] <= UP_FILT;
                     cnt_q[i]   <= 20'd0;
                  end
               end
               UP_FILT: begin
                  if (!key_s_q[i]) begin
                     state_q[i] <= HELD;
                     cnt_q[i]   <= 20'd0;
                  end else if (cnt_q[i] == CNT_MAX) begin
                     state_q[i] <= IDLE;
                     cnt_q[i]   <= 20'd0;
                  end else begin
                     cnt_q[i] <= cnt_q[i] + 20'd1;
                  end
               end
               default: begin
                  state_q[i] <= IDLE;
                  cnt_q[i]   <= 20'd0;
               end
            endcase
         end
         wr_flag <= press_d[0];
         rd_flag <= press_d[1] & ~press_d[0];
      end
   end

endmodule

// File: doc/key_cmd_gen.md
KEY_CMD_GEN -- requirements
Module: key_cmd_gen

Interface
REQ-001 The block SHALL have parameter CNT_MAX, default 20'd999_999, giving the debounce count: 20 ms at 50 MHz, with CNT_MAX+1 stable samples required.
REQ-002 The block SHALL have port sys_clk, input, 1 bit: the single clock; all logic runs on its rising edge.
REQ-003 The block SHALL have port sys_rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port key_wr, input, 1 bit: raw write key, asynchronous, active-low (0 = pressed).
REQ-005 The block SHALL have port key_rd, input, 1 bit: raw read key, asynchronous, active-low (0 = pressed).
REQ-006 The block SHALL have port wr_flag, output, 1 bit: one-cycle pulse per confirmed write-key press; feeds the RAM controller wr_flag.
REQ-007 The block SHALL have port rd_flag, output, 1 bit: one-cycle pulse per confirmed read-key press; feeds the RAM controller rd_flag.

Function
REQ-008 Each key SHALL pass through a 2-flop synchronizer before any other logic; the synchronized signal is key_s.
REQ-009 Each key SHALL have an independent 4-state FSM (IDLE, DOWN_FILT, HELD, UP_FILT) and a 20-bit counter, cleared on every state change.
REQ-010 In IDLE, key_s=0 SHALL move the FSM to DOWN_FILT; key_s=1 SHALL keep it in IDLE.
REQ-011 In DOWN_FILT, key_s=1 on any cycle SHALL return the FSM to IDLE with no flag; otherwise the counter SHALL increment until cnt==CNT_MAX with key_s=0, then move to HELD.
REQ-012 The DOWN_FILT->HELD transition SHALL register exactly one flag pulse, high for one sys_clk cycle, on the cycle after the transition edge.
REQ-013 With the key held clean low, the flag SHALL first be high on rising edge CNT_MAX+4 counted from the first edge that samples the raw key low (edge 1).
REQ-014 In HELD, key_s=1 SHALL move the FSM to UP_FILT; holding the key any length of time SHALL produce no further flag.
REQ-015 In UP_FILT, key_s=0 on any cycle SHALL return the FSM to HELD with no flag; otherwise, after CNT_MAX+1 consecutive key_s=1 samples, the FSM SHALL return to IDLE.
REQ-016 Bounce of any width up to CNT_MAX cycles, on press or release, SHALL produce no extra flag.
REQ-017 The counter SHALL never exceed CNT_MAX and SHALL never wrap.
REQ-018 If both keys would pulse in the same cycle, wr_flag SHALL assert and that rd pulse SHALL be dropped, not deferred.
REQ-019 wr_flag and rd_flag SHALL never be high in the same cycle.
REQ-020 Outputs SHALL be driven directly from flops, with no combinational path from key inputs.

Reset
REQ-021 While sys_rst=1, synchronizer flops SHALL be 1, both FSMs SHALL be IDLE, counters SHALL be 0, and wr_flag=rd_flag=0.
REQ-022 Reset asserted mid-debounce or mid-pulse SHALL clear the state immediately; a pending flag SHALL be lost.
REQ-023 A key still held low when reset deasserts SHALL be treated as a new press: after a full debounce it SHALL produce one flag.

Verification (CNT_MAX=9 for simulation)
REQ-024 Reset, then key_wr held low from edge 1 -> wr_flag high only on edge 13, then low; rd_flag stays 0.
REQ-025 key_rd low 6 cycles, high 2, low 6, then high -> rd_flag never asserts; FSM back in IDLE.
REQ-026 key_rd held low 50 cycles, released with 4-cycle bounce, pressed again after 20 clean high cycles -> exactly two rd_flag pulses.
REQ-027 key_wr and key_rd both fall on the same edge -> wr_flag pulses once, rd_flag stays 0 for the whole sequence.
REQ-028 sys_rst pulsed at cycle 8 of a key_wr debounce while the key stays low -> no flag before reset; one wr_flag 13 edges after reset deasserts.
